// File: rtl/delay_stream_ctrl_pkg.sv
// Shared definitions for delay_stream_ctrl: FSM states, delay-line entry layout,
// stats counter width and the delay clamp helpers.
package delay_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Line entry is {valid, last, data}; flag offsets are relative to the data width.
  localparam int unsigned ENTRY_LAST_OFS  = 0;
  localparam int unsigned ENTRY_VALID_OFS = 1;
  localparam int unsigned ENTRY_FLAG_W    = 2;

  localparam int unsigned STAT_W = 16;

  function automatic int unsigned clamp_delay(input logic [7:0] req, input int unsigned depth);
    if (req == '0) return 1;
    if (32'(req) > depth) return depth;
    return 32'(req);
  endfunction

  function automatic logic delay_out_of_range(input logic [7:0] req, input int unsigned depth);
    return (req == '0) || (32'(req) > depth);
  endfunction

endpackage

// File: rtl/delay_stream_ctrl_reg.sv
// delay_reg: DEPTH-entry shift line with a selectable read tap (in_pos = 1..DEPTH).
// Position 1 is the entry written on the most recent clock edge.
module delay_reg #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 34,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_pos,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] line [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) line[i] <= '0;
    end else begin
      line[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (in_pos == SEL_W'(i + 1)) out_data = line[i];
    end
  end

endmodule

// File: rtl/delay_stream_ctrl.sv
// delay_stream_ctrl: per-packet programmable delay of a valid/last stream.
// Optional stats outputs (pkt_count, clamp_count) enabled by DELAY_STREAM_STATS_EN.
module delay_stream_ctrl
  import delay_stream_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [7:0]        delay_req,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              clamp_err
`ifdef DELAY_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] pkt_count,
  output logic [STAT_W-1:0] clamp_count
`endif
);

  localparam int unsigned SEL_W     = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W   = WIDTH + ENTRY_FLAG_W;
  localparam int unsigned LAST_BIT  = WIDTH + ENTRY_LAST_OFS;
  localparam int unsigned VALID_BIT = WIDTH + ENTRY_VALID_OFS;

  state_t             state;
  logic [SEL_W-1:0]   cur_delay;
  logic [SEL_W-1:0]   drain_cnt;
  logic [SEL_W-1:0]   req_clamped;
  logic [SEL_W-1:0]   tap_sel;
  logic               accept;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] tap_entry;

  // Ready is gated by the reset pin so it is low during reset yet high in the
  // very first cycle after release, which a registered flag cannot provide.
  always_comb begin
    s_ready     = reset && (state != DRAIN);
    accept      = s_valid && s_ready;
    req_clamped = SEL_W'(clamp_delay(delay_req, DEPTH));
    tap_sel     = (state == IDLE) ? req_clamped : cur_delay;
  end

  always_comb begin
    push_entry             = '0;
    push_entry[WIDTH-1:0]  = s_data;
    push_entry[LAST_BIT]   = s_last;
    push_entry[VALID_BIT]  = accept;
  end

  delay_reg #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .SEL_W (SEL_W)
  ) u_line (
    .clk      (clk),
    .reset    (reset),
    .in_data  (push_entry),
    .in_pos   (tap_sel),
    .out_data (tap_entry)
  );

  always_comb begin
    m_data  = tap_entry[WIDTH-1:0];
    m_last  = tap_entry[LAST_BIT];
    m_valid = tap_entry[VALID_BIT];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_delay <= SEL_W'(DEPTH);
      drain_cnt <= '0;
      clamp_err <= 1'b0;
    end else begin
      clamp_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_delay <= req_clamped;
            clamp_err <= delay_out_of_range(delay_req, DEPTH);
            drain_cnt <= '0;
            state     <= s_last ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (accept && s_last) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // DEPTH bubble pushes flush every entry before the tap may move again.
          if (drain_cnt == SEL_W'(DEPTH - 1)) begin
            drain_cnt <= '0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DELAY_STREAM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count   <= '0;
      clamp_count <= '0;
    end else begin
      if (m_valid && m_last && (pkt_count != '1)) pkt_count <= pkt_count + 1'b1;
      if (clamp_err && (clamp_count != '1)) clamp_count <= clamp_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_delay_stream_ctrl.sv
// Bench for delay_stream_ctrl: directed scenarios plus a random stream, checked
// against a per-edge schedule of expected outputs built from the packet delay rules.
module tb_delay_stream_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [7:0]       delay_req;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             clamp_err;
`ifdef DELAY_STREAM_STATS_EN
  logic [15:0]      pkt_count;
  logic [15:0]      clamp_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: expected output keyed by the edge at which it is sampled.
  logic [WIDTH-1:0] exp_data [int];
  bit               exp_last [int];
  bit               err_at   [int];
  int               drain_end;
  bit               in_pkt;
  int               pkt_d;
  int               pkt_model;
  int               clamp_model;

  always #5 clk = ~clk;

  delay_stream_ctrl #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .delay_req (delay_req),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .clamp_err (clamp_err)
`ifdef DELAY_STREAM_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .clamp_count (clamp_count)
`endif
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc + 1, obs, exp);
    end
  endtask

  function automatic int clamp_of(input int r);
    if (r == 0) return 1;
    if (r > int'(DEPTH)) return int'(DEPTH);
    return r;
  endfunction

  task automatic model_reset();
    exp_data.delete();
    exp_last.delete();
    err_at.delete();
    drain_end   = -1;
    in_pkt      = 1'b0;
    pkt_d       = int'(DEPTH);
    pkt_model   = 0;
    clamp_model = 0;
  endtask

  task automatic do_cycle(input bit v, input bit l, input logic [WIDTH-1:0] d,
                          input logic [7:0] req, output bit acc);
    int k;
    bit rdy;
    bit ev;
    s_valid   = v;
    s_last    = l;
    s_data    = d;
    delay_req = req;
    k   = cyc + 1;
    rdy = (k > drain_end);
    ev  = exp_data.exists(k);
    @(negedge clk);
    chk("s_ready", s_ready, rdy);
    chk("m_valid", m_valid, ev);
    if (ev) begin
      chk("m_data", m_data, exp_data[k]);
      chk("m_last", m_last, exp_last[k]);
    end
    chk("clamp_err", clamp_err, err_at.exists(k));
`ifdef DELAY_STREAM_STATS_EN
    chk("pkt_count", pkt_count, pkt_model);
    chk("clamp_count", clamp_count, clamp_model);
`endif
    if (ev && exp_last[k]) pkt_model++;
    if (err_at.exists(k)) clamp_model++;
    acc = v && rdy;
    if (acc) begin
      if (!in_pkt) begin
        pkt_d = clamp_of(int'(req));
        if (req == 8'd0 || int'(req) > int'(DEPTH)) err_at[k + 1] = 1'b1;
      end
      exp_data[k + pkt_d] = d;
      exp_last[k + pkt_d] = l;
      in_pkt = !l;
      if (l) drain_end = k + int'(DEPTH);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) do_cycle(1'b0, 1'b0, $urandom, 8'($urandom_range(0, 9)), acc);
  endtask

  task automatic send(input bit l, input logic [WIDTH-1:0] d, input logic [7:0] req);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 3 * int'(DEPTH) + 4 && !acc; t++) do_cycle(1'b1, l, d, req, acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout at edge %0d: observed no accept expected accept", cyc);
    end
  endtask

  task automatic hold_reset(input int n);
    reset   = 1'b0;
    s_valid = 1'b1;
    s_last  = 1'b0;
    model_reset();
    #1;
    chk("rst_m_valid_now", m_valid, 0);
    chk("rst_s_ready_now", s_ready, 0);
    repeat (n) begin
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_clamp_err", clamp_err, 0);
`ifdef DELAY_STREAM_STATS_EN
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_clamp_count", clamp_count, 0);
`endif
      @(posedge clk);
      cyc++;
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    s_data    = '0;
    s_valid   = 1'b1;
    s_last    = 1'b0;
    delay_req = 8'd0;
    #1;
    hold_reset(3);

    // Three-beat packet at delay 2.
    send(1'b0, 32'd1, 8'd2);
    send(1'b0, 32'd2, 8'd7);
    send(1'b1, 32'd3, 8'd0);
    idle(8);

    // Clamp boundaries: 0 -> 1, 9 -> DEPTH, in-range 3.
    send(1'b1, 32'hA0, 8'd0);
    idle(6);
    send(1'b1, 32'hA9, 8'd9);
    idle(8);
    send(1'b1, 32'hA3, 8'd3);
    idle(8);
    send(1'b1, 32'hA4, 8'd4);
    idle(8);

    // Gap mid-packet; delay_req on the later beat is ignored.
    send(1'b0, 32'hAAAA, 8'd3);
    idle(1);
    send(1'b1, 32'hBBBB, 8'd1);
    idle(8);

    // Back-to-back packets with a short then a long delay.
    send(1'b0, 32'h101, 8'd1);
    send(1'b1, 32'h102, 8'd1);
    send(1'b0, 32'h201, 8'd4);
    send(1'b1, 32'h202, 8'd2);
    idle(8);

    // Reset in the middle of a packet discards in-flight beats.
    send(1'b0, 32'h11, 8'd2);
    send(1'b0, 32'h22, 8'd2);
    hold_reset(2);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit acc;
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom,
               8'($urandom_range(0, 7)), acc);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/delay_stream_ctrl.md
DELAY_STREAM_CTRL -- requirements
Module: delay_stream_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, maximum delay in clock cycles; taps 1..DEPTH.
REQ-002 Parameter: WIDTH, 32, data word width in bits.
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: s_data  in  WIDTH  upstream data word.
REQ-006 Port: s_valid  in  1  upstream beat valid.
REQ-007 Port: s_last  in  1  final beat of packet.
REQ-008 Port: s_ready  out  1  controller can accept a beat.
REQ-009 Port: delay_req  in  8  requested packet delay in cycles; sampled on the first beat only.
REQ-010 Port: m_data  out  WIDTH  delayed data word.
REQ-011 Port: m_valid  out  1  delayed beat valid; no downstream backpressure.
REQ-012 Port: m_last  out  1  delayed last marker.
REQ-013 Port: clamp_err  out  1  one-cycle pulse: delay_req out of range on a first beat.

Function
REQ-014 SHALL hold an internal delay line of DEPTH entries, each {valid, last, data}, that shifts every clock.
REQ-015 SHALL push {s_valid&s_ready, s_last, s_data} each cycle; non-accepted cycles push valid=0.
REQ-016 SHALL present the tap at position cur_delay on m_*; latency: beat accepted at edge n appears on m_* at edge n+cur_delay.
REQ-017 cur_delay SHALL equal delay_req clamped to [1, DEPTH]: 0 -> 1, >DEPTH -> DEPTH; clamp_err pulses the cycle after that first beat.
REQ-018 FSM states: IDLE, STREAM, DRAIN.
REQ-019 IDLE: s_ready=1; tap = clamp(delay_req) combinationally; accepted beat latches cur_delay; -> STREAM if !s_last, -> DRAIN if s_last.
REQ-020 STREAM: s_ready=1; cur_delay frozen; s_valid gaps pass through as m_valid=0 bubbles; accepted s_last -> DRAIN.
REQ-021 DRAIN: s_ready=0 for exactly DEPTH cycles (drain counter), pushing bubbles so every entry is invalid; then -> IDLE.
REQ-022 cur_delay SHALL change only in IDLE; never mid-packet.
REQ-023 Single-beat packet (first beat with s_last) SHALL go IDLE -> DRAIN directly.
REQ-024 delay_req is ignored on all beats other than the first.

Reset
REQ-025 While reset is low: s_ready=0, m_valid=0, m_last=0, m_data=0, clamp_err=0, all line entries invalid, cur_delay=DEPTH, state IDLE, drain counter 0.
REQ-026 Reset mid-packet SHALL discard all in-flight beats; no m_valid after release until a new accepted beat propagates.
REQ-027 s_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro DELAY_STREAM_STATS_EN: when defined, adds outputs pkt_count (16 bits, increments on each m_valid&m_last) and clamp_count (16 bits, increments on each clamp_err), both saturating, both cleared by reset; when undefined these ports and counters are absent and function is otherwise identical.

Structure
REQ-029 Shared package SHALL hold FSM state encoding (IDLE/STREAM/DRAIN), the line-entry field layout, and the stats counter width constant.
REQ-030 The delay line SHALL be sub-module delay_reg (DEPTH, WIDTH+2 wide entries, tap select in_pos) instantiated once; FSM, clamp and counters stay in delay_stream_ctrl.

Verification (DEPTH=4, WIDTH=32)
REQ-031 Reset held low 3 cycles with s_valid=1 -> s_ready=0, m_valid=0 throughout; s_ready=1 first cycle after release.
REQ-032 delay_req=2, beats 1,2,3 (last on 3) accepted edges 0..2 -> m_data 1,2,3 with m_valid at edges 2..4, m_last only at edge 4; s_ready=0 edges 3..6, 1 at edge 7.
REQ-033 delay_req=0 -> 1-cycle latency plus clamp_err pulse; delay_req=9 -> 4-cycle latency plus clamp_err pulse; delay_req=3 -> no pulse.
REQ-034 delay_req=3, beats A, gap, B(last) -> m_valid pattern 1,0,1 starting 3 edges after A; changing delay_req to 1 on beat B has no effect.
REQ-035 Packet 1 delay 1 then packet 2 delay 4 back-to-back -> no stale valid entries on m_* before packet 2's first beat at +4 edges.
REQ-036 Reset asserted mid-STREAM after 2 beats -> m_valid=0 immediately and after release until new traffic; with DELAY_STREAM_STATS_EN, pkt_count=0.
